// File: rtl/mux2x32_arbiter_pkg.sv
// mux2x32_arbiter_pkg: select codes, arbitration modes and output-register states
package mux2x32_arbiter_pkg;

    localparam logic SEL_A     = 1'b0;
    localparam logic SEL_B     = 1'b1;
    localparam bit   ARB_RR    = 1'b1;
    localparam bit   ARB_FIXED = 1'b0;
    localparam int   MUX_WIDTH = 32;

    typedef enum logic {EMPTY, FULL} ostate_e;

endpackage

// File: rtl/mux2x32_arbiter_mux.sv
// mux2x32: 32-bit two-input multiplexer, S = 0 selects A, S = 1 selects B
module mux2x32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        S,
    output logic [31:0] Y
);

    assign Y = S ? B : A;

endmodule

// File: rtl/mux2x32_arbiter.sv
// mux2x32_arbiter: two-source valid/ready arbiter feeding a one-entry registered output
module mux2x32_arbiter
    import mux2x32_arbiter_pkg::*;
#(
    parameter bit RR    = ARB_RR,
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A_data,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B_data,
    output logic             B_ready,
    output logic             Y_valid,
    output logic [WIDTH-1:0] Y_data,
    output logic             Y_src,
    input  logic             Y_ready
);

    if (WIDTH != MUX_WIDTH) begin : g_width_chk
        $error("mux2x32_arbiter: WIDTH must be 32 to match mux2x32");
    end

    ostate_e          state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d, mux_y;
    logic             src_q, src_d, last_q, last_d;
    logic             grant, slot_free, xfer_in;

    mux2x32 u_mux (
        .A (A_data),
        .B (B_data),
        .S (grant),
        .Y (mux_y)
    );

    // Readies are gated by Clrn so nothing looks accepted while reset is held.
    always_comb begin
        slot_free = (state_q == EMPTY) | Y_ready;
        grant     = (A_valid & B_valid) ? (RR ? ~last_q : SEL_A) : (B_valid ? SEL_B : SEL_A);
        A_ready   = Clrn & slot_free & A_valid & (grant == SEL_A);
        B_ready   = Clrn & slot_free & B_valid & (grant == SEL_B);
        xfer_in   = A_ready | B_ready;
        state_d   = xfer_in ? FULL : (Y_ready ? EMPTY : state_q);
        data_d    = xfer_in ? mux_y : data_q;
        src_d     = xfer_in ? grant : src_q;
        last_d    = xfer_in ? grant : last_q;
    end

    // last_grant resets to B so that A wins the first contention.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= SEL_A;
            last_q  <= SEL_B;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign Y_valid = (state_q == FULL);
    assign Y_data  = data_q;
    assign Y_src   = src_q;

endmodule

// File: tb/tb_mux2x32_arbiter.sv
// tb_mux2x32_arbiter: table-driven vectors, directed corner cases and a scoreboarded random soak
module tb_mux2x32_arbiter;
    import mux2x32_arbiter_pkg::*;

    logic        Clk = 1'b0, Clrn = 1'b1;
    logic        A_valid = 1'b0, B_valid = 1'b0, Y_ready = 1'b0;
    logic [31:0] A_data = '0, B_data = '0;
    logic        A_ready, B_ready, Y_valid, Y_src;
    logic [31:0] Y_data;
    logic        f_ar, f_br, f_yv, f_ys;
    logic [31:0] f_yd;

    mux2x32_arbiter #(.RR(ARB_RR)) dut (
        .Clk(Clk), .Clrn(Clrn),
        .A_valid(A_valid), .A_data(A_data), .A_ready(A_ready),
        .B_valid(B_valid), .B_data(B_data), .B_ready(B_ready),
        .Y_valid(Y_valid), .Y_data(Y_data), .Y_src(Y_src), .Y_ready(Y_ready)
    );

    mux2x32_arbiter #(.RR(ARB_FIXED)) fx (
        .Clk(Clk), .Clrn(Clrn),
        .A_valid(A_valid), .A_data(A_data), .A_ready(f_ar),
        .B_valid(B_valid), .B_data(B_data), .B_ready(f_br),
        .Y_valid(f_yv), .Y_data(f_yd), .Y_src(f_ys), .Y_ready(Y_ready)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard for the round-robin instance: {src, data} in acceptance order.
    logic [32:0] q[$];
    logic        a_fire = 1'b0, b_fire = 1'b0, proto_on = 1'b0;
    logic        pa = 1'b0, pb = 1'b0;
    logic [31:0] pad, pbd;
    int          a_wait = 0, b_wait = 0;

    always @(negedge Clrn) begin
        q.delete();
        a_wait = 0;
        b_wait = 0;
        pa = 1'b0;
        pb = 1'b0;
    end

    always @(negedge Clk) begin
        if (Clrn) begin
            logic [32:0] e;
            chk("both_ready", {A_ready, B_ready} == 2'b11, 0);
            chk("y_valid_vs_sb", Y_valid, q.size() != 0);
            if (Y_valid && Y_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("sb_word", {Y_src, Y_data}, e);
            end
            a_fire = A_valid & A_ready;
            b_fire = B_valid & B_ready;
            if (a_fire) q.push_back({SEL_A, A_data});
            if (b_fire) q.push_back({SEL_B, B_data});
            if (a_fire || !A_valid) a_wait = 0;
            else if (b_fire) begin a_wait++; chk("a_wait_le1", a_wait <= 1, 1); end
            if (b_fire || !B_valid) b_wait = 0;
            else if (a_fire) begin b_wait++; chk("b_wait_le1", b_wait <= 1, 1); end
            if (proto_on && pa) assert (A_valid && A_data == pad) else $error("A dropped valid or changed data before ready");
            if (proto_on && pb) assert (B_valid && B_data == pbd) else $error("B dropped valid or changed data before ready");
            pa = A_valid & !A_ready; pad = A_data;
            pb = B_valid & !B_ready; pbd = B_data;
        end else begin
            a_fire = 1'b0;
            b_fire = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge Clk); #1;
        Clrn = 1'b0; A_valid = 1'b0; B_valid = 1'b0; Y_ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Clrn = 1'b1;
    endtask

    typedef struct {bit rst, fx, av, bv, yr, ear, ebr;} vec_t;

    initial begin
        vec_t        vt[$];
        int          na, nb;
        bit          pv;
        logic [32:0] pexp;
        logic        ar, br, ys;
        logic [31:0] yd;
        // Round-robin contention: A first after reset, then strict alternation.
        vt.push_back('{1, 0, 1, 1, 1, 1, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{0, 0, 1, 1, 1, 1, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{0, 0, 1, 1, 1, 1, 0});
        vt.push_back('{0, 0, 1, 1, 1, 0, 1});
        vt.push_back('{0, 0, 0, 0, 1, 0, 0});
        // Fixed priority: A always wins; B only once A drops.
        vt.push_back('{1, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 1, 1, 1, 1, 0});
        vt.push_back('{0, 1, 0, 1, 1, 0, 1});
        vt.push_back('{0, 1, 0, 0, 1, 0, 0});

        #1 Clrn = 1'b0;
        repeat (3) begin
            A_valid = 1'($urandom); B_valid = 1'($urandom); Y_ready = 1'($urandom);
            A_data = $urandom; B_data = $urandom;
            @(negedge Clk);
            chk("rst_y_valid", Y_valid, 0);
            chk("rst_y_data", Y_data, 0);
            chk("rst_ready", {A_ready, B_ready}, 0);
            @(posedge Clk); #1;
        end
        Clrn = 1'b1; A_valid = 1'b1; A_data = 32'h1111_1111; B_valid = 1'b0; Y_ready = 1'b0;
        @(negedge Clk);
        chk("t1_a_ready", A_ready, 1);
        @(posedge Clk); #1;
        A_valid = 1'b0;
        @(negedge Clk);
        chk("t1_y", {Y_valid, Y_src, Y_data}, {1'b1, 1'b0, 32'h1111_1111});
        @(posedge Clk); #1;
        Y_ready = 1'b1;
        @(posedge Clk); #1;

        na = 0; nb = 0; pv = 0; pexp = '0;
        foreach (vt[i]) begin
            if (vt[i].rst) begin do_reset(); na = 0; nb = 0; pv = 0; end
            A_valid = vt[i].av; B_valid = vt[i].bv; Y_ready = vt[i].yr;
            A_data = 32'hAAAA_0000 + 32'(na); B_data = 32'hBBBB_0000 + 32'(nb);
            @(negedge Clk);
            ar = vt[i].fx ? f_ar : A_ready;
            br = vt[i].fx ? f_br : B_ready;
            ys = vt[i].fx ? f_ys : Y_src;
            yd = vt[i].fx ? f_yd : Y_data;
            chk($sformatf("vec%0d_a_ready", i), ar, vt[i].ear);
            chk($sformatf("vec%0d_b_ready", i), br, vt[i].ebr);
            if (pv) chk($sformatf("vec%0d_prev_word", i), {ys, yd}, pexp);
            pv = vt[i].ear | vt[i].ebr;
            pexp = vt[i].ebr ? {SEL_B, B_data} : {SEL_A, A_data};
            if (vt[i].ear) na++;
            if (vt[i].ebr) nb++;
            @(posedge Clk); #1;
        end

        do_reset();
        A_valid = 1'b1; A_data = 32'hDEAD_BEEF; Y_ready = 1'b0;
        @(posedge Clk); #1;
        A_data = 32'hAAAA_0001; B_valid = 1'b1; B_data = 32'hBBBB_0001;
        repeat (5) begin
            @(negedge Clk);
            chk("bp_ready", {A_ready, B_ready}, 0);
            chk("bp_y", {Y_valid, Y_data}, {1'b1, 32'hDEAD_BEEF});
            @(posedge Clk); #1;
        end
        Y_ready = 1'b1;
        @(negedge Clk);
        chk("bp_release_ready", {A_ready, B_ready}, 2'b01);
        @(posedge Clk); #1;
        B_valid = 1'b0;
        @(negedge Clk);
        chk("bp_no_bubble", {Y_valid, Y_src, Y_data}, {1'b1, 1'b1, 32'hBBBB_0001});
        chk("bp_a_next", A_ready, 1);
        @(posedge Clk); #1;
        A_valid = 1'b0;
        @(posedge Clk); #1;

        do_reset();
        A_valid = 1'b1; A_data = 32'h5555_0001; Y_ready = 1'b0;
        @(posedge Clk); #1;
        A_valid = 1'b0;
        @(negedge Clk);
        chk("t5_full", Y_valid, 1);
        #1 Clrn = 1'b0;
        #1 chk("t5_async_clear", {Y_valid, Y_data}, 0);
        @(posedge Clk); #1;
        Clrn = 1'b1; A_valid = 1'b1; B_valid = 1'b1; Y_ready = 1'b1;
        A_data = 32'h5555_0002; B_data = 32'h6666_0002;
        @(negedge Clk);
        chk("t5_a_first", {A_ready, B_ready}, 2'b10);
        @(posedge Clk); #1;
        A_valid = 1'b0;
        @(negedge Clk);
        chk("t5_b_next", B_ready, 1);
        @(posedge Clk); #1;
        B_valid = 1'b0;

        do_reset();
        proto_on = 1'b1;
        repeat (10000) begin
            if (!A_valid || a_fire) begin A_valid = 1'($urandom); A_data = $urandom; end
            if (!B_valid || b_fire) begin B_valid = 1'($urandom); B_data = $urandom; end
            Y_ready = $urandom_range(0, 3) != 0;
            @(posedge Clk); #1;
        end
        proto_on = 1'b0;
        A_valid = 1'b0; B_valid = 1'b0; Y_ready = 1'b1;
        repeat (3) begin @(posedge Clk); #1; end
        @(negedge Clk);
        chk("soak_drained", q.size(), 0);
        chk("soak_y_empty", Y_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux2x32_arbiter.md
Name: mux2x32_arbiter

Overview:
Two-requester, 32-bit round-robin arbiter that shares one downstream 32-bit channel between sources A and B. Each side uses a valid/ready handshake. The arbiter drives the select of an internal MUX2X32 and captures the selected word into a one-entry output register, so the output is fully registered. It sits in front of shared CPU resources such as a memory write port or a writeback bus.

Parameters:
RR, 1, 1 = round-robin priority; 0 = fixed priority with A always winning.
WIDTH, 32, data width. Fixed at 32 to match MUX2X32; any other value is a synthesis error.

Ports:
Clk  input  1  rising-edge clock
Clrn  input  1  asynchronous active-low reset
A_valid  input  1  source A has a word
A_data  input  32  source A word
A_ready  output  1  A word accepted this cycle
B_valid  input  1  source B has a word
B_data  input  32  source B word
B_ready  output  1  B word accepted this cycle
Y_valid  output  1  output register holds a word
Y_data  output  32  registered word
Y_src  output  1  source of Y_data (0 = A, 1 = B)
Y_ready  input  1  downstream accepts Y_data

Behaviour:
- One clock domain (Clk). Clrn is asynchronous and active-low.
- Reset values:
  - Y_valid = 0, Y_data = 32'h0, Y_src = 0.
  - last_grant = 1, so A wins the first contention.
- Output register states:
  - EMPTY: Y_valid = 0.
  - FULL: Y_valid = 1.
- slot_free = !Y_valid | Y_ready. This is combinational, so the path from Y_ready to A_ready/B_ready is intended.
- Grant, combinational, computed every cycle:
  - Only A_valid set → A. Only B_valid set → B.
  - Both set, RR = 1 → the source not equal to last_grant. Both set, RR = 0 → A.
  - Neither set → no grant.
- The grant drives MUX2X32 input S (0 = A, 1 = B).
- A_ready = slot_free & grant == A. B_ready = slot_free & grant == B. At most one ready is high per cycle.
- Transfer on an input occurs when valid & ready. On that edge:
  - Y_data ← mux output, Y_src ← grant, Y_valid ← 1.
  - last_grant ← grant.
- Transfer on the output occurs when Y_valid & Y_ready. If there is no simultaneous input transfer, Y_valid ← 0 and Y_data/Y_src hold their values.
- Simultaneous output drain and input transfer: the register is replaced in the same edge and Y_valid stays 1. This gives sustained throughput of one word per cycle and latency of one cycle from input transfer to Y_valid.
- FULL with Y_ready = 0: both readys are 0, and Y_data/Y_src/Y_valid are stable until drained.
- Sources must hold valid and data until ready. Valid must not depend on ready. Dropping valid without a transfer is a protocol violation; the bench flags it with an assertion, and the RTL takes no special action.
- The grant is recomputed every cycle. No grant is held across stalled cycles, because a requester that did not transfer has not consumed priority.
- last_grant changes only on an input transfer.
- Reset asserted mid-operation clears the state immediately (asynchronously); any pending word is lost. After Clrn deasserts, the first rising edge can accept a word.
- Fairness, RR = 1: with both valids held continuously and Y_ready = 1, grants strictly alternate. No source waits more than one transfer.

Decomposition:
- Shared header, include-guarded like the other MUX headers, defines:
  - `SEL_A = 1'b0`, `SEL_B = 1'b1`
  - `ARB_RR = 1`, `ARB_FIXED = 0`
- Sub-module: instantiate the existing MUX2X32 for the data selection (A = A_data, B = B_data, S = grant).
- The grant/round-robin logic stays inline; no further sub-module is needed.

Test Plan:
1. Reset: hold Clrn = 0 with random inputs → Y_valid = 0, Y_data = 0, A_ready = B_ready = 0. Release, drive A_valid = 1, A_data = 32'h1111_1111 → A_ready = 1; next cycle Y_valid = 1, Y_data = 32'h1111_1111, Y_src = 0.
2. Contention, RR = 1, Y_ready = 1: A_data = 32'hAAAA_0000 + n, B_data = 32'hBBBB_0000 + n, both valid for 6 cycles → Y_src sequence 0,1,0,1,0,1 with matching data and one word per cycle.
3. Backpressure: Y_ready = 0 while FULL holding 32'hDEAD_BEEF, A and B both valid → A_ready = B_ready = 0 and Y_data is stable for 5 cycles. Raise Y_ready → the same cycle grants the round-robin winner, and Y_data updates next edge with no bubble.
4. Fixed priority, RR = 0: both valid for 4 cycles → Y_src = 0 every cycle. Drop A_valid → B granted next cycle.
5. Reset mid-stream: Clrn = 0 asynchronously while Y_valid = 1 → Y_valid = 0 before the next Clk edge. After release, with both valid, A wins first.
6. Random soak: 10k cycles of random valids, data and Y_ready against a scoreboard. Check:
   - no loss or duplication;
   - per-source order preserved;
   - each source waits at most one transfer under RR = 1;
   - never both readys high.
